instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the single-cycle datapath. Owns the fetch PC and issues

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, reset vector, fetch FSM state encoding and a pointer-width helper
// for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Redirect, instruction-memory and instruction-output signals of the fetch unit.
// master = fetch unit side, slave = datapath/memory side.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
// Used for both the response buffer and the in-flight PC tag queue.
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO accepts a push only when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues up to DEPTH in-flight word requests, buffers in-order
// responses, flushes on redirect. Optional macro IFU_ALIGN_CHK_EN adds misalign_err.
//   state  | meaning
//   S_BOOT | one idle cycle after reset
//   S_RUN  | requests allowed while credit remains
//   S_HOLD | in-flight + buffered == DEPTH, wait for a slot or redirect
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         bus,
  output logic                       misalign_err
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = INSTR_W + ADDR_W;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic              redirect, fire, rsp_keep, pop;
  logic [ADDR_W-1:0] redirect_aligned, tag_head;
  logic [CNT_W-1:0]  fifo_count, fifo_count_d;
  logic [OCC_W-1:0]  occ, occ_d;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_wdata, head;
  logic [CNT_W-1:0]  tag_count_unused;
  logic              tag_empty_unused;

  assign redirect         = bus.redirect_valid;
  assign redirect_aligned = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign occ              = OCC_W'(outst_q) + OCC_W'(fifo_count);

  assign bus.imem_req  = (state_q == S_RUN) && !redirect && (occ < OCC_W'(DEPTH));
  assign bus.imem_addr = fetch_pc_q;
  assign fire          = bus.imem_req && bus.imem_gnt;

  assign rsp_keep = bus.imem_rvalid && (discard_q == '0) && !redirect;
  assign pop      = bus.instr_ready && !fifo_empty && !redirect;

  assign fifo_wdata      = {bus.imem_rdata, tag_head};
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head[ENT_W-1:ADDR_W];
  assign bus.instr_pc    = head[ADDR_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CNT_W'(fire) - CNT_W'(bus.imem_rvalid);
    if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
    // Every response still owed after a redirect belongs to the old stream.
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      discard_d  = outst_d;
    end else if (bus.imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_comb begin
    fifo_count_d = redirect ? '0 : (fifo_count + CNT_W'(rsp_keep) - CNT_W'(pop));
    occ_d        = OCC_W'(outst_d) + OCC_W'(fifo_count_d);
    state_d      = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (occ_d >= OCC_W'(DEPTH)) state_d = S_HOLD;
      S_HOLD:  if (redirect || (occ_d < OCC_W'(DEPTH))) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  instr_fetch_unit_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (tag_head),
    .count_o (tag_count_unused),
    .empty_o (tag_empty_unused)
  );

  instr_fetch_unit_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_rsp_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (rsp_keep),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

`ifdef IFU_ALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  logic [1:0] redirect_lo_unused;

  assign redirect_lo_unused = bus.redirect_pc[1:0];
  assign misalign_err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFU_ALIGN_CHK_EN
  localparam bit EXP_MIS = 1'b1;
`else
  localparam bit EXP_MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic misalign_err;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus_if();

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if.master),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } flight_t;

  flight_t     inflight[$];
  logic [63:0] m_fifo[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;
  bit          m_booted, m_err, m_valid;
  int          n_cmp = 0, n_fail = 0, n_pops = 0;

  int          c_occ;
  bit          c_req_exp, c_pop, c_redir;
  flight_t     c_ent;
  logic [31:0] c_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare, then advance to the state after the coming posedge.
  always @(negedge clk) begin
    #2;
    c_redir = bus_if.redirect_valid;
    if (m_valid) begin
      c_occ     = inflight.size() + m_fifo.size();
      c_req_exp = m_booted && !c_redir && (c_occ < DEPTH);
      chk("imem_req", 32'(bus_if.imem_req), 32'(c_req_exp));
      if (c_req_exp) chk("imem_addr", bus_if.imem_addr, m_pc);
      chk("instr_valid", 32'(bus_if.instr_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        chk("instr", bus_if.instr, m_fifo[0][63:32]);
        chk("instr_pc", bus_if.instr_pc, m_fifo[0][31:0]);
      end
      chk("misalign_err", 32'(misalign_err), 32'(m_err));
    end else begin
      c_req_exp = 1'b0;
    end

    if (rst) begin
      inflight.delete();
      m_fifo.delete();
      mem_q.delete();
      m_pc     = 32'h0;
      m_booted = 1'b0;
      m_err    = 1'b0;
      m_valid  = 1'b1;
    end else begin
      if (bus_if.imem_rvalid && mem_q.size() > 0) c_addr = mem_q.pop_front();
      if (bus_if.imem_req && bus_if.imem_gnt) mem_q.push_back(bus_if.imem_addr);

      c_pop = bus_if.instr_ready && (m_fifo.size() > 0) && !c_redir;
      if (c_pop) begin
        void'(m_fifo.pop_front());
        n_pops++;
      end
      if (bus_if.imem_rvalid && inflight.size() > 0) begin
        c_ent = inflight.pop_front();
        if (!c_ent.drop && !c_redir) m_fifo.push_back({memf(c_ent.addr), c_ent.addr});
      end
      if (c_req_exp && bus_if.imem_gnt) begin
        inflight.push_back('{addr: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (c_redir) begin
        m_fifo.delete();
        foreach (inflight[i]) inflight[i].drop = 1'b1;
        m_pc = {bus_if.redirect_pc[31:2], 2'b00};
        if (EXP_MIS && bus_if.redirect_pc[1:0] != 2'b00) m_err = 1'b1;
      end
      m_booted = 1'b1;
    end
  end

  task automatic step(input bit rs, input bit redir, input logic [31:0] rpc,
                      input bit gnt, input bit rv_en, input bit rdy);
    @(negedge clk);
    rst                   = rs;
    bus_if.redirect_valid = redir;
    bus_if.redirect_pc    = rpc;
    bus_if.imem_gnt       = gnt;
    bus_if.instr_ready    = rdy;
    if (rv_en && !rs && mem_q.size() > 0) begin
      bus_if.imem_rvalid = 1'b1;
      bus_if.imem_rdata  = memf(mem_q[0]);
    end else begin
      bus_if.imem_rvalid = 1'b0;
      bus_if.imem_rdata  = 32'h0;
    end
    #3;
  endtask

  task automatic do_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      ok = bus_if.instr_valid;
    end
    chk({name, "_wait"}, 32'(ok), 32'd1);
    if (ok) chk({name, "_pc"}, bus_if.instr_pc, exp_pc);
  endtask

  initial begin
    int gcnt;
    int pops_before;
    bit seen;
    bit rs, redir, gnt, rv, rdy;
    logic [31:0] rpc;

    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.imem_gnt       = 1'b0;
    bus_if.imem_rvalid    = 1'b0;
    bus_if.imem_rdata     = 32'h0;
    bus_if.instr_ready    = 1'b0;

    // Streaming after reset with a 1-cycle memory
    do_reset();
    chk("rst_req", 32'(bus_if.imem_req), 32'd0);
    chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (i == 1) chk("t1_boot_req", 32'(bus_if.imem_req), 32'd0);
      if (i == 2) begin
        chk("t1_req", 32'(bus_if.imem_req), 32'd1);
        chk("t1_addr0", bus_if.imem_addr, 32'h0);
      end
      if (i == 3) begin
        chk("t1_addr1", bus_if.imem_addr, 32'h4);
        chk("t1_no_bypass", 32'(bus_if.instr_valid), 32'd0);
      end
      if (i == 4) begin
        chk("t1_addr2", bus_if.imem_addr, 32'h8);
        chk("t1_first_valid", 32'(bus_if.instr_valid), 32'd1);
        chk("t1_pc0", bus_if.instr_pc, 32'h0);
        chk("t1_instr0", bus_if.instr, 32'h5A5A_C3C3);
      end
      if (i == 5) chk("t1_pc1", bus_if.instr_pc, 32'h4);
    end

    // Consumer stalled: credit limit
    do_reset();
    gcnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (bus_if.imem_req && bus_if.imem_gnt) gcnt++;
    end
    chk("t2_grants", 32'(gcnt), 32'(DEPTH));
    chk("t2_req_held", 32'(bus_if.imem_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      seen = bus_if.imem_req;
    end
    chk("t2_resume", 32'(seen), 32'd1);

    // Two requests in flight, redirect to 0x100
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t3_addr", bus_if.imem_addr, 32'h100);
    wait_valid("t3", 32'h100);

    // Redirect in the same cycle as a pop and a response
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("t4_valid_before", 32'(bus_if.instr_valid), 32'd1);
    chk("t4_rvalid", 32'(bus_if.imem_rvalid), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t4_valid_after", 32'(bus_if.instr_valid), 32'd0);
    wait_valid("t4", 32'h200);

    // Wrap at the top of the address space
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t5_addr_top", bus_if.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t5_addr_wrap", bus_if.imem_addr, 32'h0);

    // Misaligned redirect
    step(1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t6_misalign", 32'(misalign_err), 32'(EXP_MIS));
    chk("t6_addr", bus_if.imem_addr, 32'h100);

    // Random traffic against the model
    do_reset();
    pops_before = n_pops;
    for (int i = 0; i < 3000; i++) begin
      rs    = ($urandom_range(0, 599) == 0);
      redir = ($urandom_range(0, 29) == 0);
      rpc   = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc[31:4] = 28'hFFF_FFFF;
      gnt   = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      step(rs, redir, rpc, gnt, rv, rdy);
    end
    chk("rand_progress", 32'(n_pops - pops_before > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
